mult_div_unit: RTL

//  Parametrised MIPS HI/LO multiply/divide unit: next generation of the single-cycle

---
 rtl/mult_div_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit for the execute stage: width-generic multiplier with
// configurable latency and a restoring divider producing one quotient bit per cycle.
module mult_div_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned DIV_EN  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       mult_func,
  output logic [WIDTH-1:0] c_mult,
  output logic             busy,
  output logic             stall
);

  localparam logic [3:0] MULT_NOTHING       = 4'd0;
  localparam logic [3:0] MULT_READ_LO       = 4'd1;
  localparam logic [3:0] MULT_READ_HI       = 4'd2;
  localparam logic [3:0] MULT_WRITE_LO      = 4'd3;
  localparam logic [3:0] MULT_WRITE_HI      = 4'd4;
  localparam logic [3:0] MULT_MULT          = 4'd5;
  localparam logic [3:0] MULT_SIGNED_MULT   = 4'd6;
  localparam logic [3:0] MULT_DIVIDE        = 4'd7;
  localparam logic [3:0] MULT_SIGNED_DIVIDE = 4'd8;

  localparam int unsigned CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned MUL_CNT = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_prod;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dsr;
  logic               r_neg_q;
  logic               r_neg_r;

  logic               w_smul;
  logic               w_sdiv;
  logic               w_div_go;
  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;

  // Operand preparation, divider step and sign fix-up
  always_comb begin
    w_smul   = (mult_func == MULT_SIGNED_MULT);
    w_sdiv   = (mult_func == MULT_SIGNED_DIVIDE);
    w_div_go = (DIV_EN != 0) && (b != '0) &&
               ((mult_func == MULT_DIVIDE) || (mult_func == MULT_SIGNED_DIVIDE));
    w_a_ext  = w_smul ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    w_b_ext  = w_smul ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    w_prod   = w_a_ext * w_b_ext;
    w_a_abs  = (w_sdiv && a[WIDTH-1]) ? -a : a;
    w_b_abs  = (w_sdiv && b[WIDTH-1]) ? -b : b;
    w_shift  = {r_rem, r_quo[WIDTH-1]};
    w_diff   = w_shift - {1'b0, r_dsr};
    w_q_fix  = r_neg_q ? -r_quo : r_quo;
    w_r_fix  = r_neg_r ? -r_rem : r_rem;
  end

  // Pipeline handshake and MFHI/MFLO read path
  always_comb begin
    busy   = (r_state != S_IDLE);
    stall  = busy && (mult_func != MULT_NOTHING);
    c_mult = '0;
    if (!busy) begin
      if (mult_func == MULT_READ_LO) c_mult = r_lo;
      else if (mult_func == MULT_READ_HI) c_mult = r_hi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dsr   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          case (mult_func)
            MULT_WRITE_LO: r_lo <= a;
            MULT_WRITE_HI: r_hi <= a;
            MULT_MULT, MULT_SIGNED_MULT: begin
              if (MUL_LAT <= 1) begin
                {r_hi, r_lo} <= w_prod;
              end else begin
                r_prod  <= w_prod;
                r_cnt   <= CNT_W'(MUL_CNT);
                r_state <= S_MUL;
              end
            end
            MULT_DIVIDE, MULT_SIGNED_DIVIDE: begin
              if (w_div_go) begin
                r_rem   <= '0;
                r_quo   <= w_a_abs;
                r_dsr   <= w_b_abs;
                r_neg_q <= w_sdiv && (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg_r <= w_sdiv && a[WIDTH-1];
                r_cnt   <= CNT_W'(WIDTH - 1);
                r_state <= S_DIV;
              end
            end
            default: ;
          endcase
        end
        S_MUL: begin
          if (r_cnt == '0) begin
            {r_hi, r_lo} <= r_prod;
            r_state      <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DIV: begin
          // Restoring step: keep the trial difference only when it did not borrow
          if (!w_diff[WIDTH]) begin
            r_rem <= w_diff[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
          if (r_cnt == '0) r_state <= S_FIX;
          else r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          r_lo    <= w_q_fix;
          r_hi    <= w_r_fix;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
